ex_stage: RTL and testbench

// - Consumer of the 152-bit ID/EX pipeline bus: unpacks fields, forwards operands, executes ALU op.
// - Computes the branch target and registers the result onto the 107-bit EX/MEM bus.
// - Sits between the ID/EX register and the MEM stage; drives stall back to IF/ID/ID-EX.

---
 rtl/ex_pkg.sv | 63 ++++++
 rtl/ex_alu.sv | 43 ++++
 rtl/ex_stage.sv | 149 ++++++++++++++
 tb/tb_ex_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg: ALU/funct/FSM encodings and the ID/EX and EX/MEM bus layouts for ex_stage.
// Bus structs assume the fixed 32-bit datapath.
package ex_pkg;

  localparam int IDEX_W  = 152;
  localparam int EXMEM_W = 107;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ORI   = 2'b11;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
  } ex_ctl_t;

  // Member order matches the ID/EX bit layout, MSB first.
  typedef struct packed {
    logic [4:0]  rs;
    logic [1:0]  wb;
    logic [2:0]  m;
    ex_ctl_t     ex;
    logic [31:0] add4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] target;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  dest;
  } exmem_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational EX ALU. valid=0 flags an unrecognised R-type funct
// (result forced to 0) so the stage can kill the writeback.
module ex_alu
  import ex_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [15:0]  imm,
  input  logic [4:0]   shamt,
  input  logic [1:0]   aluop,
  input  logic [5:0]   funct,
  output logic [W-1:0] result,
  output logic         valid
);

  always_comb begin
    result = '0;
    valid  = 1'b1;
    case (aluop)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_ORI: result = a | {{(W-16){1'b0}}, imm};
      default: begin
        case (funct)
          F_ADD, F_ADDU: result = a + b;
          F_SUB, F_SUBU: result = a - b;
          F_AND:         result = a & b;
          F_OR:          result = a | b;
          F_XOR:         result = a ^ b;
          F_NOR:         result = ~(a | b);
          F_SLT:         result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
          F_SLTU:        result = {{(W-1){1'b0}}, a < b};
          F_SLL:         result = b << shamt;
          F_SRL:         result = b >> shamt;
          default:       valid  = 1'b0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, branch target and EX/MEM register.
// Define MULDIV_EN to add multu/mfhi/mflo with HI/LO and a shift-add multiply FSM.
module ex_stage
  import ex_pkg::*;
#(
  parameter int W = 32
`ifdef MULDIV_EN
  , parameter int MUL_CYC = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDEX_W-1:0]  in,
  input  logic               flush,
  input  logic               exmem_regwrite,
  input  logic [4:0]         exmem_rd,
  input  logic [W-1:0]       exmem_result,
  input  logic               memwb_regwrite,
  input  logic [4:0]         memwb_rd,
  input  logic [W-1:0]       memwb_result,
  output logic [EXMEM_W-1:0] out,
  output logic               stall
);

  idex_t        id;
  exmem_t       nxt, out_q;
  logic [W-1:0] fwd_a, fwd_b, opb, alu_res, res;
  logic         alu_ok, res_ok;

  assign id = idex_t'(in);

  // The younger producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == id.rs)      fwd_a = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == id.rs) fwd_a = memwb_result;
    else                                                              fwd_a = id.rd1;
  end

  always_comb begin
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == id.rt)      fwd_b = exmem_result;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == id.rt) fwd_b = memwb_result;
    else                                                              fwd_b = id.rd2;
  end

  assign opb = id.ex.alusrc ? id.sext : fwd_b;

  ex_alu #(.W(W)) u_alu (
    .a      (fwd_a),
    .b      (opb),
    .imm    (id.sext[15:0]),
    .shamt  (id.sext[10:6]),
    .aluop  (id.ex.aluop),
    .funct  (id.sext[5:0]),
    .result (alu_res),
    .valid  (alu_ok)
  );

`ifdef MULDIV_EN
  localparam int              CW   = $clog2(MUL_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(MUL_CYC - 1);

  logic [1:0]   state;
  logic [CW-1:0] cnt;
  logic [W-1:0] hi, lo, acc_hi, acc_lo, mcand;
  logic [W:0]   psum;
  logic         is_rtype, is_mul;

  assign is_rtype = (id.ex.aluop == ALU_RTYPE);
  assign is_mul   = is_rtype && (id.sext[5:0] == F_MULTU);

  // One shift-add step: {acc_hi,acc_lo} holds the partial product with the
  // remaining multiplier bits in the low half.
  assign psum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign stall = !rst && ((state == ST_IDLE && is_mul) || state == ST_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      mcand  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (is_mul) begin
          mcand  <= fwd_a;
          acc_lo <= opb;
          acc_hi <= '0;
          cnt    <= '0;
          state  <= ST_BUSY;
        end
        ST_BUSY: begin
          acc_hi <= psum[W:1];
          acc_lo <= {psum[0], acc_lo[W-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi    <= psum[W:1];
            lo    <= {psum[0], acc_lo[W-1:1]};
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // multu itself falls through as an unknown funct: alu=0 and wb killed on retire.
  always_comb begin
    res    = alu_res;
    res_ok = alu_ok;
    if (is_rtype && id.sext[5:0] == F_MFHI) begin
      res    = hi;
      res_ok = 1'b1;
    end else if (is_rtype && id.sext[5:0] == F_MFLO) begin
      res    = lo;
      res_ok = 1'b1;
    end
  end
`else
  assign res    = alu_res;
  assign res_ok = alu_ok;
  assign stall  = 1'b0;
`endif

  always_comb begin
    nxt        = '0;
    nxt.wb     = res_ok ? id.wb : 2'b00;
    nxt.m      = id.m;
    nxt.target = id.add4 + {id.sext[W-3:0], 2'b00};
    nxt.zero   = (res == '0);
    nxt.alu    = res;
    nxt.wdata  = fwd_b;
    nxt.dest   = id.ex.regdst ? id.rd : id.rt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                out_q <= '0;
    else if (flush || stall) out_q <= '0;
    else                    out_q <= nxt;
  end

  assign out = out_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + randomized checks of ex_stage against a behavioural model.
// Multiply-path checks are compiled in when MULDIV_EN is defined.
module tb_ex_stage;

  localparam int MUL_CYC = 32;
  localparam logic [5:0] FL [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                       6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h3F, 6'h10, 6'h19};

  logic         clk = 1'b0;
  logic         rst;
  logic [151:0] in;
  logic         flush;
  logic         exmem_regwrite, memwb_regwrite;
  logic [4:0]   exmem_rd, memwb_rd;
  logic [31:0]  exmem_result, memwb_result;
  logic [106:0] out;
  logic         stall;

  ex_stage dut (
    .clk(clk), .rst(rst), .in(in), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out(out), .stall(stall)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;
  bit run = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [151:0] mk(input logic [4:0] rs, input logic [1:0] wb, input logic [2:0] m,
                                      input logic [3:0] ex, input logic [31:0] add4, input logic [31:0] rd1,
                                      input logic [31:0] rd2, input logic [31:0] sext,
                                      input logic [4:0] rt, input logic [4:0] rd);
    return {rs, wb, m, ex, add4, rd1, rd2, sext, rt, rd};
  endfunction

  // ---------------- behavioural model ----------------
  logic [106:0] exp_out;
  int           m_busy;
  bit           m_done;
  logic [31:0]  m_hi, m_lo;
  logic [63:0]  m_prod;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] dflt);
    if (exmem_regwrite && r != 0 && exmem_rd == r) return exmem_result;
    if (memwb_regwrite && r != 0 && memwb_rd == r) return memwb_result;
    return dflt;
  endfunction

  function automatic logic [31:0] op_a(input logic [151:0] b);
    return fwd(b[151:147], b[105:74]);
  endfunction

  function automatic logic [31:0] op_b(input logic [151:0] b);
    return b[138] ? b[41:10] : fwd(b[9:5], b[73:42]);
  endfunction

  function automatic bit is_multu(input logic [151:0] b);
`ifdef MULDIV_EN
    return b[140:139] == 2'b10 && b[15:10] == 6'h19;
`else
    return (b == 152'd0) && (b != 152'd0);
`endif
  endfunction

  function automatic logic [106:0] model(input logic [151:0] b);
    logic [31:0] a, bo, s, r;
    logic [1:0]  wb;
    s  = b[41:10];
    a  = op_a(b);
    bo = op_b(b);
    wb = b[146:145];
    r  = 32'd0;
    case (b[140:139])
      2'd0: r = a + bo;
      2'd1: r = a - bo;
      2'd3: r = a | {16'h0, s[15:0]};
      default: case (s[5:0])
        6'h20, 6'h21: r = a + bo;
        6'h22, 6'h23: r = a - bo;
        6'h24: r = a & bo;
        6'h25: r = a | bo;
        6'h26: r = a ^ bo;
        6'h27: r = ~(a | bo);
        6'h2A: r = ($signed(a) < $signed(bo)) ? 32'd1 : 32'd0;
        6'h2B: r = (a < bo) ? 32'd1 : 32'd0;
        6'h00: r = bo << s[10:6];
        6'h02: r = bo >> s[10:6];
`ifdef MULDIV_EN
        6'h10: r = m_hi;
        6'h12: r = m_lo;
`endif
        default: wb = 2'b00;
      endcase
    endcase
    return {wb, b[144:142], b[137:106] + (s << 2), r == 32'd0, r, fwd(b[9:5], b[73:42]),
            b[141] ? b[4:0] : b[9:5]};
  endfunction

  function automatic bit exp_stall();
    return (m_busy > 0) || (!m_done && is_multu(in));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_out <= '0; m_busy <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_prod <= '0;
    end else if (flush) begin
      exp_out <= '0; m_busy <= 0; m_done <= 1'b0;
    end else if (m_busy > 0) begin
      exp_out <= '0;
      m_busy  <= m_busy - 1;
      if (m_busy == 1) begin
        m_done <= 1'b1;
        m_hi   <= m_prod[63:32];
        m_lo   <= m_prod[31:0];
      end
    end else if (!m_done && is_multu(in)) begin
      exp_out <= '0;
      m_busy  <= MUL_CYC;
      m_prod  <= {32'd0, op_a(in)} * {32'd0, op_b(in)};
    end else begin
      exp_out <= model(in);
      m_done  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && run) begin
      chk("out", 128'(out), 128'(exp_out));
      chk("stall", 128'(stall), 128'(exp_stall()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [151:0] rand_instr();
    logic [31:0] s;
    s      = $urandom;
    s[5:0] = FL[$urandom_range(0, 14)];
    return mk(5'($urandom_range(0, 7)), 2'($urandom), 3'($urandom), 4'($urandom), $urandom,
              $urandom, $urandom, s, 5'($urandom_range(0, 7)), 5'($urandom));
  endfunction

  logic [151:0] i_add, i_mfhi, i_mflo, i_mul;
  int  n;
  bit  st, fl;

  initial begin
    rst = 1'b1; in = '0; flush = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
    i_add  = mk(5'd1, 2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
    i_mul  = mk(5'd1, 2'b00, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd2, 32'h19, 5'd2, 5'd0);
    i_mfhi = mk(5'd0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd0, 32'd0, 32'h10, 5'd0, 5'd5);
    i_mflo = mk(5'd0, 2'b10, 3'b000, 4'b1100, 32'h0, 32'd0, 32'd0, 32'h12, 5'd0, 5'd5);
    #12;
    chk("reset_out", 128'(out), 128'(0));
    chk("reset_stall", 128'(stall), 128'(0));
    @(negedge clk); #2; rst = 1'b0; run = 1'b1;
    cyc();

    in = i_add; cyc();
    chk("add_alu", 128'(out[68:37]), 128'(32'd12));
    chk("add_dest", 128'(out[4:0]), 128'(5'd3));
    chk("add_wb", 128'(out[106:105]), 128'(2'b10));

    in = mk(5'd4, 2'b10, 3'b000, 4'b0001, 32'h0, 32'h55, 32'h0, 32'h0, 5'd5, 5'd6);
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h100;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h200;
    cyc(); chk("fwd_exmem", 128'(out[68:37]), 128'(32'h100));
    exmem_rd = 5'd0; cyc(); chk("fwd_memwb", 128'(out[68:37]), 128'(32'h200));
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    cyc(); chk("fwd_none", 128'(out[68:37]), 128'(32'h55));

    in = mk(5'd1, 2'b00, 3'b100, 4'b0010, 32'h40, 32'd9, 32'd9, 32'd3, 5'd2, 5'd0);
    cyc();
    chk("beq_zero", 128'(out[69]), 128'(1'b1));
    chk("beq_target", 128'(out[101:70]), 128'(32'h4C));
    chk("beq_m", 128'(out[104:102]), 128'(3'b100));

    in = mk(5'd1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd2, 5'd3);
    cyc(); chk("slt", 128'(out[68:37]), 128'(32'd1));
    in[15:10] = 6'h2B;
    cyc(); chk("sltu", 128'(out[68:37]), 128'(32'd0));
    in = mk(5'd1, 2'b10, 3'b000, 4'b1100, 32'h0, 32'h0, 32'd1, 32'h7C0, 5'd2, 5'd3);
    cyc(); chk("sll31", 128'(out[68:37]), 128'(32'h80000000));
    in[15:10] = 6'h3F;
    cyc(); chk("unknown_wb", 128'(out[106:105]), 128'(2'b00));

    in = i_add; flush = 1'b1;
    cyc(); chk("flush_out", 128'(out), 128'(0));
    flush = 1'b0;

`ifdef MULDIV_EN
    in = i_mul;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall) n++;
      else break;
    end
    chk("mul_stall_cycles", 128'(n), 128'(33));
    cyc(); chk("mul_retire_wb", 128'(out[106:105]), 128'(2'b00));
    in = i_mfhi; cyc(); chk("mfhi", 128'(out[68:37]), 128'(32'd1));
    in = i_mflo; cyc(); chk("mflo", 128'(out[68:37]), 128'(32'hFFFFFFFE));

    in = i_mul;
    repeat (11) cyc();
    rst = 1'b1; #1;
    chk("rst_busy_out", 128'(out), 128'(0));
    chk("rst_busy_stall", 128'(stall), 128'(0));
    in = i_mfhi;
    @(negedge clk); #2; rst = 1'b0;
    cyc(); chk("rst_hi", 128'(out[68:37]), 128'(0));
    in = i_mflo; cyc(); chk("rst_lo", 128'(out[68:37]), 128'(0));
`else
    in = i_mul; cyc();
    chk("multu_unknown_wb", 128'(out[106:105]), 128'(2'b00));
    chk("multu_unknown_alu", 128'(out[68:37]), 128'(0));
`endif

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      st = stall; fl = flush;
      @(posedge clk); #1;
      if (!st || fl) in = rand_instr();
      flush          = ($urandom_range(0, 15) == 0);
      exmem_regwrite = 1'($urandom);
      exmem_rd       = 5'($urandom_range(0, 7));
      exmem_result   = $urandom;
      memwb_regwrite = 1'($urandom);
      memwb_rd       = 5'($urandom_range(0, 7));
      memwb_result   = $urandom;
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
